seven_segment_reader: RTL



---
 rtl/seven_segment_reader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/seven_segment_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_reader
//  Description : Monitors a time-multiplexed, active-low seven-segment bus.
//                Waits for the bus to be stable, then turns the lit segment
//                pattern back into a BCD value for whichever digit is enabled.
//                Reports per-digit values with valid flags, plus strobes for
//                unknown patterns, bad scan vectors and completed frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seven_segment,
    input  logic [NUM_DIGITS-1:0]     digit_enable_n,
    output logic [4*NUM_DIGITS-1:0]   bcd_digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      pattern_error,
    output logic                      scan_error,
    output logic                      frame_done
);

    localparam int c_W     = NUM_DIGITS + 7;
    localparam int c_CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_SAT  = c_CNT_W'(SETTLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    logic [c_W-1:0]        r_sync1;
    logic [c_W-1:0]        r_sync2;
    logic [c_W-1:0]        r_prev;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_CNT_W-1:0]    w_count_inc;
    logic                  w_changed;
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_capture;
    logic [NUM_DIGITS-1:0] w_active;
    logic                  w_one_hot;
    logic [6:0]            w_seg;
    logic [3:0]            w_dec_value;
    logic                  w_dec_valid;
    logic                  w_dec_bad;
    logic [NUM_DIGITS-1:0] r_seen;
    logic                  w_seen_full;
    logic [NUM_DIGITS-1:0] w_seen_base;

    // Enable bits are active-low: a 0 means that digit is being driven.
    assign w_active    = ~r_sync2[c_W-1:7];
    assign w_seg       = r_sync2[6:0];
    assign w_one_hot   = $onehot(w_active);
    assign w_changed   = (r_sync2 != r_prev);
    assign w_count_inc = (r_count == c_SAT) ? r_count : (r_count + c_ONE);
    assign w_seen_full = &r_seen;
    // A completed frame empties the mask on the cycle frame_done is raised.
    assign w_seen_base = w_seen_full ? '0 : r_seen;

    // Two-flop synchronizer, previous-sample register and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
            r_count <= '0;
        end else begin
            r_sync1 <= {digit_enable_n, seven_segment};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_count <= w_changed ? '0 : w_count_inc;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; capture fires on the edge the count reaches its last value.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_changed) begin
                    w_state_next = ST_SETTLING;
                end
            end
            ST_SETTLING: begin
                if (w_changed) begin
                    w_state_next = ST_SETTLING;
                end else if (w_count_inc == c_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (w_changed) begin
                    w_state_next = ST_SETTLING;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Inverse of the BCD-to-seven-segment encoding (active-low, bit0 = a).
    always_comb begin
        w_dec_value = 4'hE;
        w_dec_valid = 1'b0;
        w_dec_bad   = 1'b0;
        case (w_seg)
            7'h40: begin w_dec_value = 4'd0; w_dec_valid = 1'b1; end
            7'h79: begin w_dec_value = 4'd1; w_dec_valid = 1'b1; end
            7'h24: begin w_dec_value = 4'd2; w_dec_valid = 1'b1; end
            7'h30: begin w_dec_value = 4'd3; w_dec_valid = 1'b1; end
            7'h19: begin w_dec_value = 4'd4; w_dec_valid = 1'b1; end
            7'h12: begin w_dec_value = 4'd5; w_dec_valid = 1'b1; end
            7'h02: begin w_dec_value = 4'd6; w_dec_valid = 1'b1; end
            7'h78: begin w_dec_value = 4'd7; w_dec_valid = 1'b1; end
            7'h00: begin w_dec_value = 4'd8; w_dec_valid = 1'b1; end
            7'h10: begin w_dec_value = 4'd9; w_dec_valid = 1'b1; end
            7'h7F: begin w_dec_value = 4'hF; end
            default: begin
                w_dec_value = 4'hE;
                w_dec_bad   = 1'b1;
            end
        endcase
    end

    // Capture datapath: digit registers, seen mask and the three strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_digits    <= '1;
            digit_valid   <= '0;
            pattern_error <= 1'b0;
            scan_error    <= 1'b0;
            frame_done    <= 1'b0;
            r_seen        <= '0;
        end else begin
            pattern_error <= 1'b0;
            scan_error    <= 1'b0;
            frame_done    <= w_seen_full;
            r_seen        <= w_seen_base;
            if (w_capture) begin
                if (w_one_hot) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (w_active[i]) begin
                            bcd_digits[4*i +: 4] <= w_dec_value;
                            digit_valid[i]       <= w_dec_valid;
                        end
                    end
                    r_seen        <= w_seen_base | w_active;
                    pattern_error <= w_dec_bad;
                end else if (|w_active) begin
                    // Two or more digits on at once: nothing trustworthy to record.
                    scan_error <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
